// File: rtl/ram_err_mon_pkg.sv
// ram_err_monitor shared package: default widths, popcount width
// and the saturating-add helper used by the error counters.
package ram_err_mon_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LANE_W = 4;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_CNT_W  = 16;

    function automatic int popcnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Adds a+b and clamps to 2^w-1 (w <= 32).
    // Bit 32 of the result flags that a clamp happened.
    function automatic logic [32:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned w
    );
        logic [32:0] s;
        logic [32:0] mx;
        s  = {1'b0, a} + {1'b0, b};
        mx = (33'd1 << w) - 33'd1;
        if (s > mx) begin
            return {1'b1, mx[31:0]};
        end
        return {1'b0, s[31:0]};
    endfunction

endpackage

// File: rtl/ram_err_monitor_if.sv
// ram_err_monitor bus: RAM-side compare strobe/address/data in,
// SPI-side clear/threshold in, counters/flags/capture out.
interface ram_err_monitor_if
    import ram_err_mon_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              chk_valid;
    logic [ADDR_W-1:0] chk_addr;
    logic [DATA_W-1:0] x1_in;
    logic [DATA_W-1:0] x2_in;
    logic              cnt_clear;
    logic [CNT_W-1:0]  err_thresh;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  word_err_count;
    logic              err_sat;
    logic              err_flag;
    logic              busy;
    logic              first_err_valid;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_syn;

    modport master (
        output chk_valid, chk_addr, x1_in, x2_in,
        output cnt_clear, err_thresh,
        input  err_count, word_err_count, err_sat,
        input  err_flag, busy,
        input  first_err_valid, first_err_addr, first_err_syn
    );

    modport slave (
        input  chk_valid, chk_addr, x1_in, x2_in,
        input  cnt_clear, err_thresh,
        output err_count, word_err_count, err_sat,
        output err_flag, busy,
        output first_err_valid, first_err_addr, first_err_syn
    );
endinterface

// File: rtl/ram_lane_popcount.sv
// ram_lane_popcount: combinational count of set bits in one lane.
// Ports: lane_i (LANE_W bits in), cnt_o (popcount out).
module ram_lane_popcount
    import ram_err_mon_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W
) (
    input  logic [LANE_W-1:0]           lane_i,
    output logic [popcnt_w(LANE_W)-1:0] cnt_o
);
    localparam int CW = popcnt_w(LANE_W);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < LANE_W; i++) begin
            cnt_o = cnt_o + CW'(lane_i[i]);
        end
    end
endmodule

// File: rtl/ram_err_monitor.sv
// ram_err_monitor: 3-stage RAM read-back checker with saturating
// bit/word error counters, threshold alarm and optional first-error
// capture (enabled by RAM_ERR_MON_FIRST_ERR_EN).
// Ports: clk, all_clear (sync active-high), mon (slave bus).
module ram_err_monitor
    import ram_err_mon_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANE_W = DEF_LANE_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic              clk,
    input logic              all_clear,
    ram_err_monitor_if.slave mon
);
    localparam int NL = DATA_W / LANE_W;
    localparam int LW = popcnt_w(LANE_W);
    localparam int BW = popcnt_w(DATA_W);

    if (DATA_W % LANE_W != 0) begin : g_bad_lane
        $error("DATA_W must be a multiple of LANE_W");
    end

    logic              v1_q;
    logic [DATA_W-1:0] syn1_q;
    logic              v2_q;
    logic [BW-1:0]     bits2_q;
    logic [BW-1:0]     bits_d;
    logic [LW-1:0]     lane_cnt [NL];

    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  werr_q, werr_d;
    logic              sat_q, sat_d;
    logic              flag_q, flag_d;
    logic [32:0]       err_s, werr_s;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        ram_lane_popcount #(.LANE_W(LANE_W)) u_pc (
            .lane_i (syn1_q[g*LANE_W +: LANE_W]),
            .cnt_o  (lane_cnt[g])
        );
    end

    always_comb begin
        bits_d = '0;
        for (int i = 0; i < NL; i++) begin
            bits_d = bits_d + BW'(lane_cnt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (all_clear) begin
            v1_q    <= 1'b0;
            syn1_q  <= '0;
            v2_q    <= 1'b0;
            bits2_q <= '0;
        end else begin
            v1_q    <= mon.chk_valid;
            syn1_q  <= mon.x1_in ^ mon.x2_in;
            v2_q    <= v1_q;
            bits2_q <= bits_d;
        end
    end

    // Soft clear overrides any result arriving at ACC on the same edge.
    always_comb begin
        err_s  = sat_add(32'(err_q), 32'(bits2_q), CNT_W);
        werr_s = sat_add(32'(werr_q), {31'd0, bits2_q != '0}, CNT_W);
        err_d  = err_q;
        werr_d = werr_q;
        sat_d  = sat_q;
        if (v2_q) begin
            err_d  = CNT_W'(err_s[31:0]);
            werr_d = CNT_W'(werr_s[31:0]);
            sat_d  = sat_q | err_s[32] | werr_s[32];
        end
        flag_d = (mon.err_thresh != '0) && (err_d >= mon.err_thresh);
        if (mon.cnt_clear) begin
            err_d  = '0;
            werr_d = '0;
            sat_d  = 1'b0;
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (all_clear) begin
            err_q  <= '0;
            werr_q <= '0;
            sat_q  <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            werr_q <= werr_d;
            sat_q  <= sat_d;
            flag_q <= flag_d;
        end
    end

`ifdef RAM_ERR_MON_FIRST_ERR_EN
    logic [ADDR_W-1:0] addr1_q, addr2_q, cap_addr_q;
    logic [DATA_W-1:0] syn2_q, cap_syn_q;
    logic              cap_v_q;

    always_ff @(posedge clk) begin
        if (all_clear) begin
            addr1_q <= '0;
            addr2_q <= '0;
            syn2_q  <= '0;
        end else begin
            addr1_q <= mon.chk_addr;
            addr2_q <= addr1_q;
            syn2_q  <= syn1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (all_clear || mon.cnt_clear) begin
            cap_v_q    <= 1'b0;
            cap_addr_q <= '0;
            cap_syn_q  <= '0;
        end else if (v2_q && bits2_q != '0 && !cap_v_q) begin
            cap_v_q    <= 1'b1;
            cap_addr_q <= addr2_q;
            cap_syn_q  <= syn2_q;
        end
    end

    assign mon.first_err_valid = cap_v_q;
    assign mon.first_err_addr  = cap_addr_q;
    assign mon.first_err_syn   = cap_syn_q;
`else
    assign mon.first_err_valid = 1'b0;
    assign mon.first_err_addr  = '0;
    assign mon.first_err_syn   = '0;
`endif

    assign mon.err_count      = err_q;
    assign mon.word_err_count = werr_q;
    assign mon.err_sat        = sat_q;
    assign mon.err_flag       = flag_q;
    assign mon.busy           = v1_q | v2_q;
endmodule
